// File: rtl/mipi_patgen_pkg.sv
// mipi_patgen_pkg: shared types and constants for the MIPI CSI-2 TX test-pattern generator.
// Holds the FSM state encoding, pattern_sel codes, colour-bar palette and pixel-packing widths.
package mipi_patgen_pkg;

    localparam int PIX_W       = 24;
    localparam int PIX_PER_CLK = 2;
    localparam int COORD_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VS,
        ST_VBP,
        ST_HS,
        ST_HBP,
        ST_ACT,
        ST_HFP,
        ST_VFP
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS,
        PAT_RAMP,
        PAT_CHECKER,
        PAT_SOLID
    } pattern_t;

    // Element 0 is the leftmost bar (white), element 7 the rightmost (black).
    localparam logic [7:0][PIX_W-1:0] BAR_RGB = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/mipi_patgen_pixel.sv
// mipi_patgen_pixel: combinational colour of one pixel from its coordinates and the pattern code.
// Ports: x, y - pixel column / line; pattern - pattern_sel code; rgb - {R, G, B} result.
module mipi_patgen_pixel
    import mipi_patgen_pkg::*;
#(
    parameter int             H_ACTIVE  = 1280,
    parameter logic [23:0]    SOLID_RGB = 24'h808080
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         pattern,
    output logic [PIX_W-1:0]   rgb
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar;
    logic       unused_y;

    // x never reaches H_ACTIVE, so the quotient always fits in three bits.
    assign bar      = 3'(x / COORD_W'(BAR_W));
    assign unused_y = ^{y[COORD_W-1:6], y[4:0]};

    always_comb begin
        rgb = pattern == PAT_BARS    ? BAR_RGB[bar] :
              pattern == PAT_RAMP    ? {3{x[7:0]}} :
              pattern == PAT_CHECKER ? ((x[5] ^ y[5]) ? 24'h000000 : 24'hFFFFFF) :
                                       SOLID_RGB;
    end

endmodule

// File: rtl/mipi_tx_pattern_gen.sv
// mipi_tx_pattern_gen: generic-frame-mode video pattern source for the CSI-2 TX parallel port,
// 2 pixels per clock, RGB888.
// Ports: tx_pixel_clk / tx_pixel_rstn (sync, active-low) - clock and reset;
//        enable - run frames; pattern_sel - 0 bars, 1 ramp, 2 checker, 3 solid;
//        tx_valid / tx_hsync / tx_vsync / tx_data - registered video beat;
//        frame_cnt - completed frames; busy - FSM not idle.
// Optional: define MIPI_PATGEN_FRAME_TAG_EN to stamp {8'hA5, frame_cnt} into pixel 0 of each frame.
module mipi_tx_pattern_gen
    import mipi_patgen_pkg::*;
#(
    parameter int          H_ACTIVE  = 1280,
    parameter int          V_ACTIVE  = 720,
    parameter int          HS_WIDTH  = 4,
    parameter int          HBP       = 8,
    parameter int          HFP       = 8,
    parameter int          VS_WIDTH  = 4,
    parameter int          VBP       = 64,
    parameter int          VFP       = 64,
    parameter logic [23:0] SOLID_RGB = 24'h808080
) (
    input  logic        tx_pixel_clk,
    input  logic        tx_pixel_rstn,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        tx_valid,
    output logic        tx_hsync,
    output logic        tx_vsync,
    output logic [63:0] tx_data,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    state_t             state, nstate;
    logic [15:0]        cnt, ncnt, line, nline, len, nframe;
    logic [COORD_W-1:0] x0, x1;
    logic [1:0]         pat, npat;
    logic               done;
    logic [PIX_W-1:0]   rgb0, rgb1;
    logic [63:0]        ndata;

    // Cycles spent in each timed state; cnt counts from 0 to len-1.
    always_comb begin
        len = state == ST_VS  ? 16'(VS_WIDTH) :
              state == ST_VBP ? 16'(VBP) :
              state == ST_HS  ? 16'(HS_WIDTH) :
              state == ST_HBP ? 16'(HBP) :
              state == ST_ACT ? 16'(H_ACTIVE / 2) :
              state == ST_HFP ? 16'(HFP) :
                                16'(VFP);
    end

    assign done = cnt == len - 16'd1;

    always_comb begin
        nstate = state;
        ncnt   = cnt + 16'd1;
        nline  = line;
        npat   = pat;
        nframe = frame_cnt;
        if (state == ST_IDLE) begin
            ncnt = '0;
            if (enable) begin
                nstate = ST_VS;
                npat   = pattern_sel;
                nline  = '0;
            end
        end else if (done) begin
            ncnt = '0;
            case (state)
                ST_VS:  nstate = ST_VBP;
                ST_VBP: nstate = ST_HS;
                ST_HS:  nstate = ST_HBP;
                ST_HBP: nstate = ST_ACT;
                ST_ACT: nstate = ST_HFP;
                ST_HFP: begin
                    if (line < 16'(V_ACTIVE - 1)) begin
                        nline  = line + 16'd1;
                        nstate = ST_HS;
                    end else begin
                        nstate = ST_VFP;
                    end
                end
                ST_VFP: begin
                    nframe = frame_cnt + 16'd1;
                    nline  = '0;
                    nstate = enable ? ST_VS : ST_IDLE;
                    npat   = enable ? pattern_sel : pat;
                end
                default: nstate = ST_IDLE;
            endcase
        end
    end

    // Pixel coordinates of the beat about to be registered.
    assign x0 = {ncnt[COORD_W-2:0], 1'b0};
    assign x1 = {ncnt[COORD_W-2:0], 1'b1};

    mipi_patgen_pixel #(.H_ACTIVE(H_ACTIVE), .SOLID_RGB(SOLID_RGB)) u_pix0 (
        .x(x0), .y(nline), .pattern(pat), .rgb(rgb0)
    );

    mipi_patgen_pixel #(.H_ACTIVE(H_ACTIVE), .SOLID_RGB(SOLID_RGB)) u_pix1 (
        .x(x1), .y(nline), .pattern(pat), .rgb(rgb1)
    );

    always_comb begin
        ndata = nstate == ST_ACT ? {{(64 - PIX_W * PIX_PER_CLK){1'b0}}, rgb1, rgb0} : '0;
`ifdef MIPI_PATGEN_FRAME_TAG_EN
        if (nstate == ST_ACT && ncnt == '0 && nline == '0) ndata[23:0] = {8'hA5, frame_cnt};
`else
        ndata = ndata;
`endif
    end

    // Outputs are registered from the next state so sync, valid and data share one edge.
    always_ff @(posedge tx_pixel_clk) begin
        if (!tx_pixel_rstn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            line      <= '0;
            pat       <= '0;
            frame_cnt <= '0;
            tx_valid  <= 1'b0;
            tx_hsync  <= 1'b0;
            tx_vsync  <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= nstate;
            cnt       <= ncnt;
            line      <= nline;
            pat       <= npat;
            frame_cnt <= nframe;
            tx_valid  <= nstate == ST_ACT;
            tx_hsync  <= nstate == ST_HS;
            tx_vsync  <= nstate == ST_VS;
            tx_data   <= ndata;
            busy      <= nstate != ST_IDLE;
        end
    end

endmodule

// File: tb/tb_mipi_tx_pattern_gen.sv
// tb_mipi_tx_pattern_gen: directed self-checking bench for mipi_tx_pattern_gen.
module tb_mipi_tx_pattern_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        enable2 = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        tx_valid, tx_hsync, tx_vsync, busy;
    logic [63:0] tx_data;
    logic [15:0] frame_cnt;
    logic        v2, h2, vs2, b2;
    logic [63:0] d2;
    logic [15:0] f2;
    int          tests = 0;
    int          fails = 0;
    logic [63:0] beats [16];

`ifdef MIPI_PATGEN_FRAME_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    always #5 clk = ~clk;

    mipi_tx_pattern_gen #(
        .H_ACTIVE(32), .V_ACTIVE(4), .HS_WIDTH(2), .HBP(2), .HFP(2),
        .VS_WIDTH(2), .VBP(4), .VFP(4)
    ) dut (
        .tx_pixel_clk(clk), .tx_pixel_rstn(rstn), .enable(enable), .pattern_sel(pattern_sel),
        .tx_valid(tx_valid), .tx_hsync(tx_hsync), .tx_vsync(tx_vsync), .tx_data(tx_data),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    mipi_tx_pattern_gen #(
        .H_ACTIVE(128), .V_ACTIVE(4), .HS_WIDTH(2), .HBP(2), .HFP(2),
        .VS_WIDTH(2), .VBP(4), .VFP(4)
    ) dut_chk (
        .tx_pixel_clk(clk), .tx_pixel_rstn(rstn), .enable(enable2), .pattern_sel(2'd2),
        .tx_valid(v2), .tx_hsync(h2), .tx_vsync(vs2), .tx_data(d2),
        .frame_cnt(f2), .busy(b2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!tx_valid && n < 500) begin
            tick();
            n++;
        end
        check(tag, 64'(tx_valid), 64'd1);
    endtask

    function automatic logic [63:0] first_beat(input logic [63:0] plain, input logic [15:0] f);
        return TAG ? {plain[63:24], 8'hA5, f} : plain;
    endfunction

    initial begin
        int vs_n, hs_n, val_n, bad_n, lb, done_at, r, n, seen;
        int hs_at [8];
        logic [2:0] vs_bits;
        logic pv, ph;

        @(negedge clk);
        repeat (3) tick();
        check("rst_ctl", 64'({tx_valid, tx_hsync, tx_vsync, busy}), 64'd0);
        check("rst_data", tx_data, 64'd0);
        check("rst_fcnt", 64'(frame_cnt), 64'd0);

        // Release with enable: one full colour-bar frame is profiled.
        rstn = 1'b1;
        enable = 1'b1;
        vs_n = 0; hs_n = 0; val_n = 0; bad_n = 0; lb = 0; done_at = -1;
        pv = 1'b0; ph = 1'b0; vs_bits = '0;
        for (int c = 0; c < 300 && done_at < 0; c++) begin
            tick();
            if (frame_cnt == 16'd1) done_at = c;
            else begin
                if (c < 3) vs_bits[c] = tx_vsync;
                if (tx_vsync && !pv) vs_n++;
                if (tx_hsync && !ph) begin
                    if (hs_n < 8) hs_at[hs_n] = c;
                    hs_n++;
                    lb = 0;
                end
                if (tx_valid) begin
                    if (hs_n == 1 && lb < 16) beats[lb] = tx_data;
                    lb++;
                    val_n++;
                end
                if (!tx_valid && tx_data != 64'd0) bad_n++;
                pv = tx_vsync;
                ph = tx_hsync;
            end
        end
        check("vs_shape", 64'(vs_bits), 64'b011);
        check("vs_pulses", 64'(vs_n), 64'd1);
        check("hs_pulses", 64'(hs_n), 64'd4);
        check("valid_beats", 64'(val_n), 64'd64);
        check("first_hs", 64'(hs_at[0]), 64'd6);
        check("line_period_a", 64'(hs_at[1] - hs_at[0]), 64'd22);
        check("line_period_b", 64'(hs_at[3] - hs_at[2]), 64'd22);
        check("frame_len", 64'(done_at), 64'd98);
        check("idle_data_zero", 64'(bad_n), 64'd0);
        check("bars_b0", beats[0], first_beat(64'h0000_FFFFFF_FFFFFF, 16'd0));
        check("bars_b1", beats[1], 64'h0000_FFFFFF_FFFFFF);
        check("bars_b2", beats[2], 64'h0000_FFFF00_FFFF00);
        check("bars_b6", beats[6], 64'h0000_00FF00_00FF00);
        check("bars_b14", beats[14], 64'd0);
        check("bars_b15", beats[15], 64'd0);

        // Reset in the middle of an active line.
        wait_valid("midact_reach");
        rstn = 1'b0;
        pattern_sel = 2'd1;
        tick();
        check("midrst_ctl", 64'({tx_valid, tx_hsync, tx_vsync, busy}), 64'd0);
        check("midrst_data", tx_data, 64'd0);
        check("midrst_fcnt", 64'(frame_cnt), 64'd0);
        rstn = 1'b1;
        tick();
        check("rel_vs", 64'(tx_vsync), 64'd1);

        // Gray ramp, line 0.
        wait_valid("ramp_reach");
        beats[0] = tx_data;
        for (int i = 1; i < 16; i++) begin
            tick();
            beats[i] = tx_data;
        end
        check("ramp_b0", beats[0], first_beat(64'h0000_010101_000000, 16'd0));
        check("ramp_b3", beats[3], 64'h0000_070707_060606);
        check("ramp_b15", beats[15], 64'h0000_1F1F1F_1E1E1E);

        // Drop enable and change pattern during line 1; frame must still finish as ramp.
        n = 0;
        while (!tx_hsync && n < 100) begin
            tick();
            n++;
        end
        check("line1_hs", 64'(tx_hsync), 64'd1);
        enable = 1'b0;
        pattern_sel = 2'd3;
        r = 0; lb = 0; ph = 1'b1; done_at = -1; beats[3] = '0;
        for (int c = 0; c < 300 && done_at < 0; c++) begin
            tick();
            if (frame_cnt == 16'd1) done_at = c;
            else begin
                if (tx_hsync && !ph) begin
                    r++;
                    lb = 0;
                end
                if (tx_valid) begin
                    if (r == 2 && lb == 3) beats[3] = tx_data;
                    lb++;
                end
                ph = tx_hsync;
            end
        end
        check("stop_lines_after", 64'(r), 64'd2);
        check("stop_ramp_kept", beats[3], 64'h0000_070707_060606);
        check("stop_busy", 64'({busy, tx_vsync}), 64'd0);
        seen = 0;
        repeat (20) begin
            tick();
            if (tx_vsync || busy) seen++;
        end
        check("stop_stays_idle", 64'(seen), 64'd0);

        // Restart: the new pattern applies from this frame.
        enable = 1'b1;
        tick();
        check("restart_vs", 64'(tx_vsync), 64'd1);
        wait_valid("solid_reach");
        check("solid_b0", tx_data, first_beat(64'h0000_808080_808080, 16'd1));
        repeat (3) tick();
        check("solid_b3", tx_data, 64'h0000_808080_808080);

        // First beat of frame 5.
        n = 0;
        while (!(frame_cnt == 16'd5 && tx_valid) && n < 1000) begin
            tick();
            n++;
        end
        check("f5_reach", 64'(frame_cnt == 16'd5 && tx_valid), 64'd1);
        check("f5_first", tx_data, first_beat(64'h0000_808080_808080, 16'd5));

        // Checker on the 128-pixel instance.
        enable2 = 1'b1;
        n = 0;
        while (!v2 && n < 200) begin
            tick();
            n++;
        end
        check("chk_reach", 64'(v2), 64'd1);
        repeat (15) tick();
        check("chk_b15_white", d2, 64'h0000_FFFFFF_FFFFFF);
        tick();
        check("chk_b16_black", d2, 64'd0);
        check("chk_b16_valid", 64'(v2), 64'd1);
        repeat (15) tick();
        check("chk_b31_black", d2, 64'd0);
        tick();
        check("chk_b32_white", d2, 64'h0000_FFFFFF_FFFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
